// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch/jump, data-memory freeze and
// multi-cycle MDU stalls, with stall/flush statistics and an MDU abort timer.
module pipe_hazard_ctrl #(
    parameter int MDU_TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_uses_rt,
    input  logic        ID_jump,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_rd,
    input  logic        EX_branch_taken,
    input  logic        MDU_start,
    input  logic        MDU_done,
    input  logic        MEM_req,
    input  logic        MEM_ready,
    output logic        pc_write,
    output logic        stall_IF_ID,
    output logic        flush_IF,
    output logic        stall_ID_EX,
    output logic        flush_ID_EX,
    output logic        stall_EX_MEM,
    output logic        flush_EX_MEM,
    output logic        flush_MEM_WB,
    output logic [1:0]  ctrl_state,
    output logic [31:0] stall_count,
    output logic [15:0] flush_count,
    output logic        mdu_timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MDU_WAIT = 2'd2
    } state_t;

    localparam logic [5:0] TIMEOUT_V = 6'(MDU_TIMEOUT);

    state_t     state_q, state_d;
    logic [5:0] wait_cnt;
    logic [5:0] wait_next;
    logic       timeout_hit;
    logic       mem_freeze;
    logic       mdu_stall;
    logic       load_use;

    assign wait_next  = wait_cnt + 6'd1;
    assign mem_freeze = MEM_req & ~MEM_ready;
    assign mdu_stall  = ~MDU_done & (((state_q == RUN) & MDU_start) | (state_q == MDU_WAIT));
    assign load_use   = EX_MemRead & (EX_rd != 5'd0) &
                        ((EX_rd == ID_rs) | (ID_uses_rt & (EX_rd == ID_rt)));
    assign ctrl_state = state_q;

    // Priority rows are mutually exclusive, so a branch/jump seen during a
    // freeze is simply held upstream and flushes once the freeze lifts.
    always_comb begin
        pc_write     = 1'b1;
        stall_IF_ID  = 1'b0;
        flush_IF     = 1'b0;
        stall_ID_EX  = 1'b0;
        flush_ID_EX  = 1'b0;
        stall_EX_MEM = 1'b0;
        flush_EX_MEM = 1'b0;
        flush_MEM_WB = 1'b0;
        if (!reset) begin
            if (mem_freeze) begin
                pc_write     = 1'b0;
                stall_IF_ID  = 1'b1;
                stall_ID_EX  = 1'b1;
                stall_EX_MEM = 1'b1;
                flush_MEM_WB = 1'b1;
            end else if (mdu_stall) begin
                pc_write     = 1'b0;
                stall_IF_ID  = 1'b1;
                stall_ID_EX  = 1'b1;
                flush_EX_MEM = 1'b1;
            end else if (EX_branch_taken) begin
                flush_IF    = 1'b1;
                flush_ID_EX = 1'b1;
            end else if (ID_jump) begin
                flush_IF = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                stall_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_freeze)
                    state_d = MEM_WAIT;
                else if (MDU_start && !MDU_done)
                    state_d = MDU_WAIT;
            end
            MEM_WAIT: begin
                if (!mem_freeze)
                    state_d = RUN;
            end
            MDU_WAIT: begin
                if (MDU_done) begin
                    state_d = RUN;
                end else if (wait_next == TIMEOUT_V) begin
                    state_d     = RUN;
                    timeout_hit = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt    <= 6'd0;
            mdu_timeout <= 1'b0;
        end else begin
            state_q  <= state_d;
            // Counter sits at zero outside MDU_WAIT, which clears it on entry.
            wait_cnt <= (state_q == MDU_WAIT) ? wait_next : 6'd0;
            if (timeout_hit)
                mdu_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= 32'd0;
            flush_count <= 16'd0;
        end else begin
            if (!pc_write && (stall_count != 32'hFFFF_FFFF))
                stall_count <= stall_count + 32'd1;
            if (flush_IF && (flush_count != 16'hFFFF))
                flush_count <= flush_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed control vectors, state
// and counter expectations checked with immediate assertions.
module tb_pipe_hazard_ctrl;

    // {pc_write, stall_IF_ID, flush_IF, stall_ID_EX, flush_ID_EX, stall_EX_MEM, flush_EX_MEM, flush_MEM_WB}
    localparam logic [7:0] C_NONE   = 8'b1000_0000;
    localparam logic [7:0] C_FREEZE = 8'b0101_0101;
    localparam logic [7:0] C_MDU    = 8'b0101_0010;
    localparam logic [7:0] C_BR     = 8'b1010_1000;
    localparam logic [7:0] C_JMP    = 8'b1010_0000;
    localparam logic [7:0] C_LU     = 8'b0100_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_rs, ID_rt, EX_rd;
    logic        ID_uses_rt, ID_jump, EX_MemRead, EX_branch_taken;
    logic        MDU_start, MDU_done, MEM_req, MEM_ready;
    logic        pc_write, stall_IF_ID, flush_IF, stall_ID_EX, flush_ID_EX;
    logic        stall_EX_MEM, flush_EX_MEM, flush_MEM_WB, mdu_timeout;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_count;
    logic [15:0] flush_count;
    logic [7:0]  ctrl_vec;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    assign ctrl_vec = {pc_write, stall_IF_ID, flush_IF, stall_ID_EX, flush_ID_EX,
                       stall_EX_MEM, flush_EX_MEM, flush_MEM_WB};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MDU_TIMEOUT(63)) dut (
        .clk(clk), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt), .ID_jump(ID_jump),
        .EX_MemRead(EX_MemRead), .EX_rd(EX_rd), .EX_branch_taken(EX_branch_taken),
        .MDU_start(MDU_start), .MDU_done(MDU_done),
        .MEM_req(MEM_req), .MEM_ready(MEM_ready),
        .pc_write(pc_write), .stall_IF_ID(stall_IF_ID), .flush_IF(flush_IF),
        .stall_ID_EX(stall_ID_EX), .flush_ID_EX(flush_ID_EX),
        .stall_EX_MEM(stall_EX_MEM), .flush_EX_MEM(flush_EX_MEM),
        .flush_MEM_WB(flush_MEM_WB), .ctrl_state(ctrl_state),
        .stall_count(stall_count), .flush_count(flush_count),
        .mdu_timeout(mdu_timeout)
    );

    task automatic chk(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ID_rs = 5'd0; ID_rt = 5'd0; ID_uses_rt = 1'b0; ID_jump = 1'b0;
        EX_MemRead = 1'b0; EX_rd = 5'd0; EX_branch_taken = 1'b0;
        MDU_start = 1'b0; MDU_done = 1'b0; MEM_req = 1'b0; MEM_ready = 1'b0;
    endtask

    // Inputs are already applied; check this cycle's controls and state,
    // clock once, then check the statistics counters.
    task automatic step(input string tag, input logic [7:0] ec, input logic [1:0] es);
        #1;
        chk(tag, "ctrl", {24'd0, ctrl_vec}, {24'd0, ec});
        chk(tag, "state", {30'd0, ctrl_state}, {30'd0, es});
        @(posedge clk);
        #1;
        if (!ec[7]) exp_stall++;
        if (ec[5]) exp_flush++;
        chk(tag, "stall_count", stall_count, 32'(exp_stall));
        chk(tag, "flush_count", {16'd0, flush_count}, 32'(exp_flush));
    endtask

    initial begin
        // Reset with hostile inputs: outputs must still be the idle row.
        clear_inputs();
        reset = 1'b1;
        MEM_req = 1'b1; EX_branch_taken = 1'b1; MDU_start = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset", "ctrl", {24'd0, ctrl_vec}, {24'd0, C_NONE});
        chk("reset", "state", {30'd0, ctrl_state}, 32'd0);
        chk("reset", "stall_count", stall_count, 32'd0);
        chk("reset", "flush_count", {16'd0, flush_count}, 32'd0);
        chk("reset", "mdu_timeout", {31'd0, mdu_timeout}, 32'd0);
        clear_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;

        step("idle", C_NONE, 2'd0);

        EX_MemRead = 1'b1; EX_rd = 5'd5; ID_rs = 5'd5;
        step("load_use_rs", C_LU, 2'd0);
        chk("load_use_rs", "stall_is_one", stall_count, 32'd1);

        EX_rd = 5'd0; ID_rs = 5'd0;
        step("load_rd0", C_NONE, 2'd0);

        EX_rd = 5'd7; ID_rs = 5'd3; ID_rt = 5'd7; ID_uses_rt = 1'b1;
        step("load_use_rt", C_LU, 2'd0);
        ID_uses_rt = 1'b0;
        step("rt_not_used", C_NONE, 2'd0);

        clear_inputs();
        ID_jump = 1'b1;
        step("jump", C_JMP, 2'd0);

        clear_inputs();
        EX_branch_taken = 1'b1; EX_MemRead = 1'b1; EX_rd = 5'd9; ID_rs = 5'd9;
        step("branch_over_lu", C_BR, 2'd0);

        // Freeze for three cycles with a taken branch held throughout.
        clear_inputs();
        EX_branch_taken = 1'b1; MEM_req = 1'b1;
        step("freeze1", C_FREEZE, 2'd0);
        step("freeze2", C_FREEZE, 2'd1);
        step("freeze3", C_FREEZE, 2'd1);
        MEM_ready = 1'b1;
        step("freeze_ready", C_BR, 2'd1);
        clear_inputs();
        step("after_freeze", C_NONE, 2'd0);

        MDU_start = 1'b1;
        step("mdu1", C_MDU, 2'd0);
        MDU_start = 1'b0;
        step("mdu2", C_MDU, 2'd2);
        step("mdu3", C_MDU, 2'd2);
        step("mdu4", C_MDU, 2'd2);
        MDU_done = 1'b1;
        step("mdu_done", C_NONE, 2'd2);
        MDU_done = 1'b0;
        step("after_mdu", C_NONE, 2'd0);

        MDU_start = 1'b1; MDU_done = 1'b1;
        step("mdu_same_cycle", C_NONE, 2'd0);
        clear_inputs();
        step("mdu_same_after", C_NONE, 2'd0);

        MEM_req = 1'b1; MDU_start = 1'b1;
        step("freeze_over_mdu", C_FREEZE, 2'd0);
        MDU_start = 1'b0; MEM_ready = 1'b1;
        step("freeze_release", C_NONE, 2'd1);
        clear_inputs();
        step("freeze_release2", C_NONE, 2'd0);

        // MDU never completes: abort after the 63rd MDU_WAIT cycle.
        MDU_start = 1'b1;
        step("to_start", C_MDU, 2'd0);
        MDU_start = 1'b0;
        for (int i = 1; i <= 62; i++) step("to_wait", C_MDU, 2'd2);
        chk("to_wait62", "mdu_timeout", {31'd0, mdu_timeout}, 32'd0);
        step("to_wait63", C_MDU, 2'd2);
        chk("to_abort", "mdu_timeout", {31'd0, mdu_timeout}, 32'd1);
        step("to_run", C_NONE, 2'd0);
        step("to_run2", C_NONE, 2'd0);
        chk("to_sticky", "mdu_timeout", {31'd0, mdu_timeout}, 32'd1);

        // Reset in the middle of an MDU wait.
        MDU_start = 1'b1;
        step("rst_mdu1", C_MDU, 2'd0);
        MDU_start = 1'b0;
        step("rst_mdu2", C_MDU, 2'd2);
        reset = 1'b1;
        #1;
        chk("mid_reset", "ctrl", {24'd0, ctrl_vec}, {24'd0, C_NONE});
        chk("mid_reset", "state", {30'd0, ctrl_state}, 32'd0);
        chk("mid_reset", "stall_count", stall_count, 32'd0);
        chk("mid_reset", "flush_count", {16'd0, flush_count}, 32'd0);
        chk("mid_reset", "mdu_timeout", {31'd0, mdu_timeout}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        step("post_reset", C_NONE, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
